rtc_bus_arbitro: RTL

- Bus controller and arbiter for the RTC's multiplexed 8-bit address/data bus.
- Shares the bus between two requesters: the write sequencer (E_esc/Dato_Dire handshake) and a read requester.
- Generates the DIR / DAT / cambio_estado phase strobes the write sequencer steps on.
- Drives the chip-level cs_n, rd_n, wr_n, a_d and ad lines with parameterised phase timing.

---
 rtl/rtc_bus_arbitro_if.sv | 34 +++
 rtl/rtc_bus_arbitro.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/rtc_bus_arbitro_if.sv
// Bus bundle between the RTC bus controller and its two requesters plus the
// chip-level multiplexed address/data pins.
interface rtc_bus_arbitro_if;
    logic       esc_req;
    logic [7:0] esc_dato;
    logic       DIR;
    logic       DAT;
    logic       cambio_estado;
    logic       lec_req;
    logic [7:0] lec_dir;
    logic [7:0] dato_leido;
    logic       lec_valid;
    logic       grant_esc;
    logic       grant_lec;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a_d;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic [7:0] ad_in;

    modport slave (
        input  esc_req, esc_dato, lec_req, lec_dir, ad_in,
        output DIR, DAT, cambio_estado, dato_leido, lec_valid,
        output grant_esc, grant_lec, cs_n, rd_n, wr_n, a_d, ad_out, ad_oe
    );

    modport master (
        output esc_req, esc_dato, lec_req, lec_dir, ad_in,
        input  DIR, DAT, cambio_estado, dato_leido, lec_valid,
        input  grant_esc, grant_lec, cs_n, rd_n, wr_n, a_d, ad_out, ad_oe
    );
endinterface

// File: rtl/rtc_bus_arbitro.sv
// RTC multiplexed-bus controller: round-robin arbitration between the write
// sequencer and a read requester, phase strobes for the sequencer and
// registered chip-level bus timing with T_PH-cycle half-phases.
module rtc_bus_arbitro #(
    parameter int unsigned T_PH = 4
) (
    input  logic               clk,
    input  logic               reset,
    rtc_bus_arbitro_if.slave   bus
);
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,  S_ARB      = 4'd1,  S_ADR_REQ  = 4'd2,
        S_ADR_WAIT = 4'd3,  S_ADR_LO   = 4'd4,  S_ADR_HI   = 4'd5,
        S_DAT_REQ  = 4'd6,  S_DAT_WAIT = 4'd7,  S_DAT_LO   = 4'd8,
        S_DAT_HI   = 4'd9,  S_FIN      = 4'd10, S_RELEASE  = 4'd11
    } state_t;

    localparam logic [7:0] C_LAST = 8'(T_PH - 1);

    state_t     r_state, w_next;
    logic [7:0] r_cnt;
    logic       r_owner;     // 1 = writer owns the current transaction
    logic       r_last;      // 1 = writer was granted last
    logic       w_pick, w_owner, w_done, w_timed, w_bad, w_txn;
    logic       w_cs_n, w_rd_n, w_wr_n, w_a_d, w_oe;
    logic       w_dir, w_dat, w_cam, w_lv;
    logic       r_cs_n, r_rd_n, r_wr_n, r_a_d, r_oe;
    logic       r_dir, r_dat, r_cam, r_lv, r_ge, r_gl;
    logic [7:0] r_ad_out, r_dato;

    // With both requesting, the one that did not win last time gets the bus.
    assign w_pick  = (bus.esc_req && bus.lec_req) ? ~r_last : bus.esc_req;
    assign w_owner = (r_state == S_IDLE) ? w_pick : r_owner;
    assign w_done  = (r_cnt == C_LAST);
    assign w_timed = (r_state == S_ADR_LO) || (r_state == S_ADR_HI) ||
                     (r_state == S_DAT_LO) || (r_state == S_DAT_HI);

    // Next-state sequencing; an unknown encoding falls back to IDLE.
    always_comb begin
        w_next = r_state;
        w_bad  = 1'b0;
        case (r_state)
            S_IDLE:     w_next = (bus.esc_req || bus.lec_req) ? S_ARB : S_IDLE;
            S_ARB:      w_next = S_ADR_REQ;
            S_ADR_REQ:  w_next = S_ADR_WAIT;
            S_ADR_WAIT: w_next = S_ADR_LO;
            S_ADR_LO:   w_next = w_done ? S_ADR_HI : S_ADR_LO;
            S_ADR_HI:   w_next = w_done ? S_DAT_REQ : S_ADR_HI;
            S_DAT_REQ:  w_next = S_DAT_WAIT;
            S_DAT_WAIT: w_next = S_DAT_LO;
            S_DAT_LO:   w_next = w_done ? S_DAT_HI : S_DAT_LO;
            S_DAT_HI:   w_next = w_done ? S_FIN : S_DAT_HI;
            S_FIN:      w_next = r_owner ? S_RELEASE : S_IDLE;
            S_RELEASE:  w_next = bus.esc_req ? S_RELEASE : S_IDLE;
            default: begin
                w_next = S_IDLE;
                w_bad  = 1'b1;
            end
        endcase
    end

    // Output decode for the state being entered, so registered outputs line up with it.
    always_comb begin
        w_cs_n = 1'b1; w_rd_n = 1'b1; w_wr_n = 1'b1; w_a_d = 1'b0; w_oe = 1'b0;
        w_dir  = 1'b0; w_dat  = 1'b0; w_cam  = 1'b0; w_lv  = 1'b0; w_txn = 1'b0;
        case (w_next)
            S_ARB:      w_txn = 1'b1;
            S_ADR_REQ: begin w_txn = 1'b1; w_dir = w_owner; end
            S_ADR_WAIT: w_txn = 1'b1;
            S_ADR_LO:  begin w_txn = 1'b1; w_cs_n = 1'b0; w_oe = 1'b1; w_wr_n = 1'b0; end
            S_ADR_HI:  begin w_txn = 1'b1; w_cs_n = 1'b0; w_oe = 1'b1; end
            S_DAT_REQ: begin w_txn = 1'b1; w_cs_n = 1'b0; w_oe = w_owner; w_dat = w_owner; end
            S_DAT_WAIT: begin w_txn = 1'b1; w_cs_n = 1'b0; w_oe = w_owner; end
            S_DAT_LO: begin
                w_txn  = 1'b1; w_cs_n = 1'b0; w_a_d = 1'b1; w_oe = w_owner;
                w_wr_n = ~w_owner; w_rd_n = w_owner;
            end
            S_DAT_HI:  begin w_txn = 1'b1; w_cs_n = 1'b0; w_a_d = 1'b1; w_oe = w_owner; end
            S_FIN:     begin w_txn = 1'b1; w_cam = w_owner; w_lv = ~w_owner; end
            S_IDLE, S_RELEASE: w_txn = 1'b0;
            default:   w_txn = 1'b0;
        endcase
    end

    // State register, half-phase counter, owner latch and round-robin history.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_owner <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) r_cnt <= 8'd0;
            else if (w_timed)      r_cnt <= r_cnt + 8'd1;
            else                   r_cnt <= r_cnt;
            if (r_state == S_IDLE && w_next == S_ARB) r_owner <= w_pick;
            else                                       r_owner <= r_owner;
            if (r_state == S_ARB) r_last <= r_owner;
            else                  r_last <= r_last;
        end
    end

    // Registered bus pins, pulses, grants, drive value and read capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cs_n <= 1'b1; r_rd_n <= 1'b1; r_wr_n <= 1'b1; r_a_d <= 1'b0; r_oe <= 1'b0;
            r_dir  <= 1'b0; r_dat  <= 1'b0; r_cam  <= 1'b0; r_lv  <= 1'b0;
            r_ge   <= 1'b0; r_gl   <= 1'b0;
            r_ad_out <= 8'h00;
            r_dato   <= 8'h00;
        end else begin
            r_cs_n <= w_cs_n; r_rd_n <= w_rd_n; r_wr_n <= w_wr_n; r_a_d <= w_a_d; r_oe <= w_oe;
            r_dir  <= w_dir;  r_dat  <= w_dat;  r_cam  <= w_cam;  r_lv  <= w_lv;
            r_ge   <= w_txn & w_owner;
            r_gl   <= w_txn & ~w_owner;
            if (w_bad)
                r_ad_out <= 8'h00;
            else if (r_state == S_ADR_WAIT)
                r_ad_out <= r_owner ? bus.esc_dato : bus.lec_dir;
            else if (r_state == S_DAT_WAIT && r_owner)
                r_ad_out <= bus.esc_dato;
            else
                r_ad_out <= r_ad_out;
            if (r_state == S_DAT_LO && w_done && !r_owner) r_dato <= bus.ad_in;
            else                                            r_dato <= r_dato;
        end
    end

    assign bus.cs_n          = r_cs_n;
    assign bus.rd_n          = r_rd_n;
    assign bus.wr_n          = r_wr_n;
    assign bus.a_d           = r_a_d;
    assign bus.ad_oe         = r_oe;
    assign bus.ad_out        = r_ad_out;
    assign bus.DIR           = r_dir;
    assign bus.DAT           = r_dat;
    assign bus.cambio_estado = r_cam;
    assign bus.lec_valid     = r_lv;
    assign bus.grant_esc     = r_ge;
    assign bus.grant_lec     = r_gl;
    assign bus.dato_leido    = r_dato;
endmodule
